// File: rtl/bram_stream_reader.sv
// Burst reader: issues credit-limited reads to a 2-cycle-latency BRAM and
// streams the returned words through a first-word-fall-through FIFO.
module bram_stream_reader #(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned ADDR_LINES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_LINES-1:0] base_addr_i,
  input  logic [ADDR_LINES:0]   len_i,
  output logic [ADDR_LINES-1:0] ram_addr_o,
  output logic                  ram_en_o,
  output logic                  ram_regce_o,
  input  logic [RAM_WIDTH-1:0]  ram_dout_i,
  output logic [RAM_WIDTH-1:0]  m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned LEN_W = ADDR_LINES + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [ADDR_LINES-1:0] addr;
  logic [LEN_W-1:0]      remaining;
  logic [1:0]            pipe_v;
  logic [1:0]            pipe_l;

  logic [RAM_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [OCC_W-1:0]      occupancy;
  logic                  credit;
  logic                  accept;
  logic                  issue;
  logic                  issue_last;
  logic                  push;
  logic                  pop;
  logic                  head_last;
  logic                  done_set;
  logic                  done_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read may issue only if every outstanding word already has a FIFO slot.
  assign occupancy = OCC_W'(count) + OCC_W'(pipe_v[0]) + OCC_W'(pipe_v[1]);
  assign credit    = occupancy < OCC_W'(FIFO_DEPTH);
  assign accept    = start_i && (len_i != '0);

  assign push      = pipe_v[1];
  assign m_valid_o = (count != '0);
  assign pop       = m_valid_o && m_ready_i;
  assign head_last = fifo_last[rd_ptr];

  assign m_data_o    = m_valid_o ? fifo_data[rd_ptr] : '0;
  assign m_last_o    = m_valid_o && head_last;
  assign ram_addr_o  = addr;
  assign ram_en_o    = issue;
  assign ram_regce_o = ~rst_i;
  assign busy_o      = (state != IDLE);
  assign done_o      = done_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        done_set = start_i && (len_i == '0);
      end
      RUN: begin
        issue      = credit;
        issue_last = credit && (remaining == LEN_W'(1));
      end
      DRAIN: begin
        done_set = pop && head_last;
      end
      default: begin
        issue = 1'b0;
      end
    endcase
  end

  // Burst address/length counters, read-latency pipeline and done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr      <= '0;
      remaining <= '0;
      pipe_v    <= '0;
      pipe_l    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_set;
      pipe_v <= {pipe_v[0], issue};
      pipe_l <= {pipe_l[0], issue_last};
      if (state == IDLE && accept) begin
        addr      <= base_addr_i;
        remaining <= len_i;
      end else if (issue) begin
        addr      <= addr + ADDR_LINES'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // FIFO pointers, occupancy and last tags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_last <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= ptr_inc(wr_ptr);
        fifo_last[wr_ptr] <= pipe_l[1];
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO data storage; head is only observed while the FIFO is non-empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_dout_i;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 2-cycle-latency BRAM model
// holding RAM[i] = i + 100.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  len;
  logic [3:0]  ram_addr;
  logic        ram_en;
  logic        ram_regce;
  logic [31:0] ram_dout;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] ram [16];
  logic [31:0] ram_q1;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned s_cyc;
  logic        rand_ready = 1'b0;

  logic [31:0] en_addr[$];
  logic [31:0] en_cyc[$];
  logic [31:0] pop_data[$];
  logic        pop_last[$];
  int          done_cnt;
  logic [31:0] done_cyc;
  logic        busy_seen;
  int          busy_err = 0;
  int          stable_err = 0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  int          exp_a1[4] = '{2, 3, 4, 5};
  int          exp_a2[4] = '{14, 15, 0, 1};

  bram_stream_reader #(
    .RAM_WIDTH  (32),
    .ADDR_LINES (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .ram_addr_o  (ram_addr),
    .ram_en_o    (ram_en),
    .ram_regce_o (ram_regce),
    .ram_dout_i  (ram_dout),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_last_o    (m_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // BRAM with output register: address captured at T, data visible in T+2
  always @(posedge clk) begin
    if (ram_en) ram_q1 <= ram[ram_addr];
    if (ram_regce) ram_dout <= ram_q1;
  end

  // Observe the DUT mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (ram_en) begin
        en_addr.push_back(32'(ram_addr));
        en_cyc.push_back(32'(cyc));
      end
      if (m_valid && m_ready) begin
        pop_data.push_back(m_data);
        pop_last.push_back(m_last);
      end
      if (done) begin
        done_cnt++;
        done_cyc = 32'(cyc);
        if (busy) busy_err++;
      end
      if (busy) busy_seen = 1'b1;
      if (hold_pending && !(m_valid && m_data == hold_data && m_last == hold_last))
        stable_err++;
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
      hold_last    = m_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_logs();
    en_addr.delete();
    en_cyc.delete();
    pop_data.delete();
    pop_last.delete();
    done_cnt  = 0;
    done_cyc  = '0;
    busy_seen = 1'b0;
  endtask

  task automatic start_burst(input logic [3:0] b, input logic [4:0] n);
    start     = 1'b1;
    base_addr = b;
    len       = n;
    s_cyc     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_en"},   32'(ram_en),    0);
    check({tag, "_regce"},    32'(ram_regce), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr),  0);
    check({tag, "_valid"},    32'(m_valid),   0);
    check({tag, "_last"},     32'(m_last),    0);
    check({tag, "_data"},     m_data,         0);
    check({tag, "_busy"},     32'(busy),      0);
    check({tag, "_done"},     32'(done),      0);
  endtask

  task automatic check_stream(input string tag, input int b, input int n);
    logic [31:0] got_d;
    logic        got_l;
    check({tag, "_nwords"}, 32'(pop_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got_d = (i < pop_data.size()) ? pop_data[i] : 32'hDEAD_BEEF;
      got_l = (i < pop_last.size()) ? pop_last[i] : 1'bx;
      check({tag, "_data"}, got_d, 32'(100 + ((b + i) % 16)));
      check({tag, "_last"}, 32'(got_l), 32'(i == n - 1));
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ram[i] = 32'(100 + i);
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    #1;
    check("regce_run", 32'(ram_regce), 1);
    tick();

    // Basic burst, full throughput
    clear_logs();
    start_burst(4'd2, 5'd4);
    wait_done(1, 100);
    repeat (4) tick();
    check("t1_nen", 32'(en_addr.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", (i < en_addr.size()) ? en_addr[i] : 32'hFFFF, 32'(exp_a1[i]));
      check("t1_cyc", (i < en_cyc.size()) ? en_cyc[i] : 32'hFFFF, 32'(s_cyc + 1 + 32'(i)));
    end
    check_stream("t1", 2, 4);
    check("t1_done", 32'(done_cnt), 1);
    check("t1_busy_idle", 32'(busy), 0);

    // Address wrap
    clear_logs();
    start_burst(4'd14, 5'd4);
    wait_done(1, 100);
    repeat (4) tick();
    check("t2_nen", 32'(en_addr.size()), 4);
    for (int i = 0; i < 4; i++)
      check("t2_addr", (i < en_addr.size()) ? en_addr[i] : 32'hFFFF, 32'(exp_a2[i]));
    check_stream("t2", 14, 4);
    check("t2_done", 32'(done_cnt), 1);

    // Full-length burst with backpressure: credit stops reads at 4
    clear_logs();
    m_ready = 1'b0;
    start_burst(4'd0, 5'd16);
    repeat (9) tick();
    check("t3_stall_en", 32'(en_addr.size()), 4);
    check("t3_stall_valid", 32'(m_valid), 1);
    check("t3_stall_head", m_data, 100);
    m_ready = 1'b1;
    wait_done(1, 200);
    repeat (4) tick();
    check("t3_nen", 32'(en_addr.size()), 16);
    check_stream("t3", 0, 16);
    check("t3_done", 32'(done_cnt), 1);

    // Zero-length request
    clear_logs();
    start_burst(4'd3, 5'd0);
    repeat (4) tick();
    check("t4_nen", 32'(en_addr.size()), 0);
    check("t4_done", 32'(done_cnt), 1);
    check("t4_done_cyc", done_cyc, 32'(s_cyc + 1));
    check("t4_busy_seen", 32'(busy_seen), 0);
    check("t4_nwords", 32'(pop_data.size()), 0);

    // Mid-burst reset after two reads, then restart on the first free cycle
    clear_logs();
    m_ready = 1'b0;
    start_burst(4'd0, 5'd8);
    n = 0;
    while (en_addr.size() < 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_two_reads", 32'(en_addr.size()), 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    clear_logs();
    check("t5_empty", 32'(m_valid), 0);
    start_burst(4'd5, 5'd2);
    wait_done(1, 100);
    repeat (6) tick();
    check("t5_nen", 32'(en_addr.size()), 2);
    check_stream("t5", 5, 2);
    check("t5_done", 32'(done_cnt), 1);

    // Random backpressure; a second start during RUN must be ignored
    clear_logs();
    rand_ready = 1'b1;
    start_burst(4'd12, 5'd7);
    tick();
    tick();
    check("t6_busy", 32'(busy), 1);
    start     = 1'b1;
    base_addr = 4'd0;
    len       = 5'd3;
    tick();
    start = 1'b0;
    wait_done(1, 400);
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    repeat (8) tick();
    check("t6_nen", 32'(en_addr.size()), 7);
    for (int i = 0; i < 7; i++)
      check("t6_addr", (i < en_addr.size()) ? en_addr[i] : 32'hFFFF, 32'((12 + i) % 16));
    check_stream("t6", 12, 7);
    check("t6_done", 32'(done_cnt), 1);

    check("busy_during_done", 32'(busy_err), 0);
    check("stall_stability", 32'(stable_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
